pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Owns the fetch PC and the PC delay pipeline (IF->ID->EX) of the core. Picks the
//  next PC: sequential, ID-stage jump or EX-stage branch redirect. Applies stalls,
//  inserts flush bubbles, and carries a valid bit with each delayed PC so that
//  downstream stages can tell real instructions from bubbles.
// PARAMETERS
//  PC_W      32  PC width in bits (matches `ISIZE)
//  PC_INC    1   sequential increment (word-addressed instruction memory)
//  RESET_PC  0   first fetch address after reset
// PORTS
//  clk           in   1     clock, all state on posedge
//  rst           in   1     synchronous, active-high reset
//  stall_i       in   1     hazard unit: hold IF and ID, bubble into EX
//  jmp_i         in   1     ID stage resolved an unconditional jump
//  jmp_target_i  in   PC_W  jump target
//  br_taken_i    in   1     EX stage resolved a taken branch
//  br_target_i   in   PC_W  branch target
//  pc_if_o       out  PC_W  current fetch address
//  pc_if_vld_o   out  1     fetch address is valid
//  pc_id_o       out  PC_W  PC of the instruction in ID
//  pc_id_vld_o   out  1     ID holds a real instruction
//  pc_ex_o       out  PC_W  PC of the instruction in EX
//  pc_ex_vld_o   out  1     EX holds a real instruction
//  flush_o       out  1     pulse: redirect taken this cycle (for IF/ID regs)
// BEHAVIOUR
//  Reset: pc_if_o=RESET_PC, all *_vld_o=0, pc_id_o=pc_ex_o=0, flush_o=0, state=BOOT.
//  FSM states: BOOT, RUN, STALL, REDIRECT.
//   BOOT: one cycle with pc_if_vld_o=0 (covers IMEM read latency). Then RUN.
//   RUN: pc_if_vld_o=1. Each cycle IF->ID->EX shift: pc_id<=pc_if,
//     pc_ex<=pc_id, and the valid bits shift with them.
//   STALL (while stall_i=1): pc_if and pc_id hold, and their valid bits hold.
//     pc_ex_vld<=0 (bubble). Return to RUN on the first cycle with stall_i=0.
//   REDIRECT: entered on a taken jump or branch.
//     pc_if<=target. flush_o=1 in the cycle the redirect is accepted.
//     Branch: pc_id_vld<=0 and pc_ex_vld<=0.
//     Jump: pc_id_vld<=0, and EX shifts normally.
//     Spend one cycle in REDIRECT with pc_if_vld_o=1, then go to RUN.
//  Priority (same cycle): rst > br_taken_i > jmp_i > stall_i > sequential.
//   A branch overrides a jump in the same cycle because the branch is older.
//   A branch or jump overrides a stall. The stall is dropped, and the hazard unit
//   re-asserts it if still needed.
//   br_taken_i or jmp_i in BOOT is ignored, because no instruction is in flight.
//  Sequential next PC = (pc_if + PC_INC) mod 2^PC_W. At the top of the range the
//   PC silently wraps to 0.
//  Latency: a redirect asserted in cycle N gives pc_if_o=target in cycle N+1.
//   The target reaches pc_id_o in N+2 and pc_ex_o in N+3 when there is no stall.
//  Reset mid-operation: in the next cycle all outputs are at their reset values,
//   regardless of any pending stall or redirect.
//  Targets are used verbatim. No alignment checking is done.
// STRUCTURE
//  Shared package/define file: PC_W (`ISIZE), RESET_PC, and the FSM state
//   encodings (2 bits).
//  One sub-module: pc_stage_reg. It is one PC_W-bit PC register plus a valid bit,
//   with hold and clear inputs. It is instantiated twice (ID, EX) and replaces
//   the plain delay registers.
//  The next-PC mux and the FSM live in this module.
// TESTING
//  1 rst for 2 cycles, release -> BOOT 1 cycle, pc_if_vld_o 0 then 1;
//    pc_if_o 0,1,2,3...; pc_id_o lags pc_if_o by 1 cycle, pc_ex_o by 2.
//  2 RUN at pc_if=8, stall_i=1 for 3 cycles -> pc_if=8, pc_id=7 held;
//    pc_ex_vld_o=0 for 3 cycles; after release pc_if=9.
//  3 pc_if=20, br_taken_i=1 with br_target_i=100 -> next cycle pc_if=100;
//    flush_o=1 for exactly 1 cycle; pc_id_vld_o=0, pc_ex_vld_o=0.
//  4 jmp_i (target 40) and br_taken_i (target 60) in the same cycle -> pc_if=60.
//    Separately, jmp_i with stall_i=1 -> pc_if=40 and the stall is ignored.
//  5 pc_if=32'hFFFF_FFFF, no stall -> next pc_if=0.
//    rst asserted during REDIRECT -> next cycle pc_if=0 and all valids 0.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared PC sequencer constants and FSM state encoding.
package pc_seq_pkg;

  localparam int unsigned ISIZE = 32;
  localparam int unsigned PC_INC_DEF = 1;
  localparam logic [ISIZE-1:0] RESET_PC_DEF = '0;

  typedef enum logic [1:0] {
    StBoot     = 2'd0,
    StRun      = 2'd1,
    StStall    = 2'd2,
    StRedirect = 2'd3
  } pc_state_e;

endpackage

// File: rtl/pc_stage_reg.sv
// One pipeline PC slot: PC register plus valid bit, with hold and clear (bubble) controls.
module pc_stage_reg #(
  parameter int unsigned PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  input  logic            clear,
  input  logic [PC_W-1:0] pc_in,
  input  logic            vld_in,
  output logic [PC_W-1:0] pc,
  output logic            vld
);

  // Clear still loads the address so a bubble carries a meaningful PC for debug.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc  <= '0;
      vld <= 1'b0;
    end else if (clear) begin
      pc  <= pc_in;
      vld <= 1'b0;
    end else if (!hold) begin
      pc  <= pc_in;
      vld <= vld_in;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC owner: next-PC selection, stall/flush control and the IF->ID->EX PC pipeline.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned      PC_W     = ISIZE,
  parameter int unsigned      PC_INC   = PC_INC_DEF,
  parameter logic [PC_W-1:0]  RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            jmp_i,
  input  logic [PC_W-1:0] jmp_target_i,
  input  logic            br_taken_i,
  input  logic [PC_W-1:0] br_target_i,
  output logic [PC_W-1:0] pc_if_o,
  output logic            pc_if_vld_o,
  output logic [PC_W-1:0] pc_id_o,
  output logic            pc_id_vld_o,
  output logic [PC_W-1:0] pc_ex_o,
  output logic            pc_ex_vld_o,
  output logic            flush_o
);

  pc_state_e       state_q;
  logic [PC_W-1:0] pc_if_q;
  logic            pc_if_vld_q;
  logic            flush_q;

  logic            booting;
  logic            take_br;
  logic            take_jmp;
  logic            redirect;
  logic            do_stall;
  logic [PC_W-1:0] pc_next;

  // Branch is older than the jump in ID, so it wins; nothing is in flight during boot.
  always_comb begin
    booting  = (state_q == StBoot);
    take_br  = !booting && br_taken_i;
    take_jmp = !booting && jmp_i && !br_taken_i;
    redirect = take_br || take_jmp;
    do_stall = !booting && !redirect && stall_i;
    if (take_br) begin
      pc_next = br_target_i;
    end else if (take_jmp) begin
      pc_next = jmp_target_i;
    end else if (booting || do_stall) begin
      pc_next = pc_if_q;
    end else begin
      pc_next = pc_if_q + PC_W'(PC_INC);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StBoot;
      pc_if_q     <= RESET_PC;
      pc_if_vld_q <= 1'b0;
      flush_q     <= 1'b0;
    end else begin
      pc_if_q     <= pc_next;
      pc_if_vld_q <= 1'b1;
      flush_q     <= redirect;
      if (redirect) begin
        state_q <= StRedirect;
      end else if (do_stall) begin
        state_q <= StStall;
      end else begin
        state_q <= StRun;
      end
    end
  end

  pc_stage_reg #(
    .PC_W (PC_W)
  ) u_id_stage (
    .clk    (clk),
    .rst    (rst),
    .hold   (do_stall),
    .clear  (redirect),
    .pc_in  (pc_if_q),
    .vld_in (pc_if_vld_q),
    .pc     (pc_id_o),
    .vld    (pc_id_vld_o)
  );

  // Stall bubbles EX; a branch squashes the instruction moving into EX, a jump does not.
  pc_stage_reg #(
    .PC_W (PC_W)
  ) u_ex_stage (
    .clk    (clk),
    .rst    (rst),
    .hold   (1'b0),
    .clear  (do_stall || take_br),
    .pc_in  (pc_id_o),
    .vld_in (pc_id_vld_o),
    .pc     (pc_ex_o),
    .vld    (pc_ex_vld_o)
  );

  assign pc_if_o     = pc_if_q;
  assign pc_if_vld_o = pc_if_vld_q;
  assign flush_o     = flush_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: boot, stall, branch/jump redirect, priority, wrap, reset.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        jmp_i;
  logic [31:0] jmp_target_i;
  logic        br_taken_i;
  logic [31:0] br_target_i;
  logic [31:0] pc_if_o;
  logic        pc_if_vld_o;
  logic [31:0] pc_id_o;
  logic        pc_id_vld_o;
  logic [31:0] pc_ex_o;
  logic        pc_ex_vld_o;
  logic        flush_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .jmp_i        (jmp_i),
    .jmp_target_i (jmp_target_i),
    .br_taken_i   (br_taken_i),
    .br_target_i  (br_target_i),
    .pc_if_o      (pc_if_o),
    .pc_if_vld_o  (pc_if_vld_o),
    .pc_id_o      (pc_id_o),
    .pc_id_vld_o  (pc_id_vld_o),
    .pc_ex_o      (pc_ex_o),
    .pc_ex_vld_o  (pc_ex_vld_o),
    .flush_o      (flush_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall_i = 1'b0; jmp_i = 1'b0; br_taken_i = 1'b0;
    jmp_target_i = '0; br_target_i = '0;
    step(); step();
    checks++; if (pc_if_o !== 32'd0) begin errors++; $display("FAIL reset_pc_if got %0d want 0", pc_if_o); end
    checks++; if ({pc_if_vld_o, pc_id_vld_o, pc_ex_vld_o} !== 3'b000) begin errors++; $display("FAIL reset_vld got %b want 000", {pc_if_vld_o, pc_id_vld_o, pc_ex_vld_o}); end
    checks++; if ({pc_id_o, pc_ex_o} !== 64'd0) begin errors++; $display("FAIL reset_pc_id_ex got %0h want 0", {pc_id_o, pc_ex_o}); end
    checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL reset_flush got %b want 0", flush_o); end
    rst = 1'b0;
  endtask

  // BOOT cycle, then pc_if 0,1,2,... with ID and EX lagging by one and two cycles.
  task automatic test_boot_seq();
    checks++; if (pc_if_vld_o !== 1'b0) begin errors++; $display("FAIL boot_vld got %b want 0", pc_if_vld_o); end
    for (int i = 0; i < 9; i++) begin
      step();
      checks++; if (pc_if_o !== 32'(i) || pc_if_vld_o !== 1'b1) begin errors++; $display("FAIL seq_if[%0d] got %0d/%b want %0d/1", i, pc_if_o, pc_if_vld_o, i); end
      checks++; if (pc_id_vld_o !== (i >= 1) || (i >= 1 && pc_id_o !== 32'(i - 1))) begin errors++; $display("FAIL seq_id[%0d] got %0d/%b want %0d/%b", i, pc_id_o, pc_id_vld_o, i - 1, i >= 1); end
      checks++; if (pc_ex_vld_o !== (i >= 2) || (i >= 2 && pc_ex_o !== 32'(i - 2))) begin errors++; $display("FAIL seq_ex[%0d] got %0d/%b want %0d/%b", i, pc_ex_o, pc_ex_vld_o, i - 2, i >= 2); end
    end
  endtask

  task automatic test_stall();
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (pc_if_o !== 32'd8 || pc_id_o !== 32'd7 || pc_id_vld_o !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d] got if=%0d id=%0d/%b want 8 7/1", i, pc_if_o, pc_id_o, pc_id_vld_o); end
      checks++; if (pc_ex_vld_o !== 1'b0) begin errors++; $display("FAIL stall_bubble[%0d] got %b want 0", i, pc_ex_vld_o); end
    end
    stall_i = 1'b0;
    step();
    checks++; if (pc_if_o !== 32'd9 || pc_id_o !== 32'd8 || pc_ex_o !== 32'd7 || pc_ex_vld_o !== 1'b1) begin errors++; $display("FAIL stall_release got %0d %0d %0d/%b want 9 8 7/1", pc_if_o, pc_id_o, pc_ex_o, pc_ex_vld_o); end
  endtask

  task automatic test_branch();
    while (pc_if_o < 32'd20) step();
    br_taken_i = 1'b1; br_target_i = 32'd100;
    step();
    br_taken_i = 1'b0;
    checks++; if (pc_if_o !== 32'd100 || flush_o !== 1'b1) begin errors++; $display("FAIL br_redirect got %0d/%b want 100/1", pc_if_o, flush_o); end
    checks++; if ({pc_id_vld_o, pc_ex_vld_o} !== 2'b00) begin errors++; $display("FAIL br_squash got %b want 00", {pc_id_vld_o, pc_ex_vld_o}); end
    step();
    checks++; if (pc_if_o !== 32'd101 || flush_o !== 1'b0 || pc_id_o !== 32'd100 || pc_id_vld_o !== 1'b1) begin errors++; $display("FAIL br_next got if=%0d fl=%b id=%0d/%b want 101 0 100/1", pc_if_o, flush_o, pc_id_o, pc_id_vld_o); end
    step();
    checks++; if (pc_ex_o !== 32'd100 || pc_ex_vld_o !== 1'b1) begin errors++; $display("FAIL br_ex_latency got %0d/%b want 100/1", pc_ex_o, pc_ex_vld_o); end
  endtask

  task automatic test_priority();
    jmp_i = 1'b1; jmp_target_i = 32'd40; br_taken_i = 1'b1; br_target_i = 32'd60;
    step();
    jmp_i = 1'b0; br_taken_i = 1'b0;
    checks++; if (pc_if_o !== 32'd60 || flush_o !== 1'b1 || pc_ex_vld_o !== 1'b0) begin errors++; $display("FAIL br_over_jmp got %0d fl=%b exv=%b want 60 1 0", pc_if_o, flush_o, pc_ex_vld_o); end
    step();
    jmp_i = 1'b1; jmp_target_i = 32'd40; stall_i = 1'b1;
    step();
    jmp_i = 1'b0; stall_i = 1'b0;
    checks++; if (pc_if_o !== 32'd40 || flush_o !== 1'b1 || pc_id_vld_o !== 1'b0) begin errors++; $display("FAIL jmp_over_stall got %0d fl=%b idv=%b want 40 1 0", pc_if_o, flush_o, pc_id_vld_o); end
    checks++; if (pc_ex_o !== 32'd60 || pc_ex_vld_o !== 1'b1) begin errors++; $display("FAIL jmp_ex_shift got %0d/%b want 60/1", pc_ex_o, pc_ex_vld_o); end
  endtask

  task automatic test_wrap_and_reset();
    br_taken_i = 1'b1; br_target_i = 32'hFFFF_FFFF;
    step();
    br_taken_i = 1'b0;
    step();
    checks++; if (pc_if_o !== 32'd0 || pc_id_o !== 32'hFFFF_FFFF || pc_id_vld_o !== 1'b1) begin errors++; $display("FAIL wrap got if=%0h id=%0h/%b want 0 ffffffff/1", pc_if_o, pc_id_o, pc_id_vld_o); end
    br_taken_i = 1'b1; br_target_i = 32'd500;
    step();
    br_taken_i = 1'b0;
    rst = 1'b1; jmp_i = 1'b1; jmp_target_i = 32'd9; stall_i = 1'b1;
    step();
    checks++; if (pc_if_o !== 32'd0 || {pc_if_vld_o, pc_id_vld_o, pc_ex_vld_o, flush_o} !== 4'b0000) begin errors++; $display("FAIL rst_mid got %0d %b want 0 0000", pc_if_o, {pc_if_vld_o, pc_id_vld_o, pc_ex_vld_o, flush_o}); end
    rst = 1'b0; jmp_i = 1'b0; stall_i = 1'b0;
    br_taken_i = 1'b1; br_target_i = 32'd77;
    step();
    br_taken_i = 1'b0;
    checks++; if (pc_if_o !== 32'd0 || pc_if_vld_o !== 1'b1 || flush_o !== 1'b0) begin errors++; $display("FAIL boot_ignores_br got %0d/%b fl=%b want 0/1 0", pc_if_o, pc_if_vld_o, flush_o); end
  endtask

  initial begin
    test_reset();
    test_boot_seq();
    test_stall();
    test_branch();
    test_priority();
    test_wrap_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
